rv_if_stage: RTL and testbench
==============================

# rv_if_stage

Instruction-fetch stage of the rv32i pipeline, directly upstream of decode, which drives the immediate extender with instr[31:7]. The stage owns the PC register and presents addresses to a synchronous-read instruction memory. It resolves `jal` locally with zero bubbles, because decode's immediate extender has no J-type path. It also accepts EX-stage redirects and hazard stalls, and drives the IF/ID pipeline register.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be 4-byte aligned.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- o_if_imem_addr  out  XLEN  address into the imem; read data returns one cycle later.
- i_if_imem_rdata  in  32  instruction for the address presented on the previous cycle.
- i_if_stall  in  1  hazard-unit stall; holds PC and IF/ID.
- i_if_redirect_valid  in  1  EX-stage taken branch or `jalr`.
- i_if_redirect_pc  in  XLEN  redirect target.
- o_if_id_valid  out  1  IF/ID slot holds a real instruction.
- o_if_id_pc  out  XLEN  PC of the IF/ID instruction.
- o_if_id_pc_plus4  out  XLEN  PC+4, the `jal` link value.
- o_if_id_instr  out  32  instruction word to decode.
- o_if_id_misalign  out  1  `jal` target misaligned (see Configuration).

## Operation
- State machine (if_state_e):
  - WAIT: entered at reset. Re-presents pc_q and moves to RUN on the next edge, when the first rdata becomes valid.
  - RUN: normal fetch.
  - HALT: misaligned `jal` detected. Fetch is frozen until a redirect arrives.
- pc_q resets to RESET_PC. Invariant: in RUN, i_if_imem_rdata is the instruction at pc_q.
- Next-address priority, highest first. o_if_imem_addr = next address; pc_q <= next address each edge.
  1. Redirect → i_if_redirect_pc; state → RUN.
  2. Stall, WAIT or HALT → pc_q (re-read, so rdata stays valid).
  3. RUN with rdata opcode 7'b1101111 → pc_q + J-imm. J-imm = sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  4. Otherwise → pc_q + 4.
- IF/ID register update:
  - Redirect: valid <= 0, instr <= NOP 32'h0000_0013. A redirect wins over a simultaneous stall.
  - Else stall: hold all fields.
  - Else: valid <= (state == RUN); capture pc_q, pc_q+4, rdata and the misalign flag.
- A `jal` is passed to decode with valid=1 so WB writes rd = pc_plus4.
- All adds are modulo 2^XLEN and wrap silently.

## Timing
- Reset values: o_if_id_valid=0, o_if_id_instr=NOP, o_if_id_pc=0, o_if_id_pc_plus4=0, o_if_id_misalign=0, o_if_imem_addr=RESET_PC, state WAIT.
- First valid IF/ID output: 2 edges after reset deassertion, PC=RESET_PC.
- Throughput: one instruction per cycle; `jal` costs 0 bubbles.
- Redirect: the instruction at the target appears in IF/ID 2 edges after the redirect cycle. The 1-bubble slot shows valid=0.
- Reset mid-operation: all state returns to reset values asynchronously; there is no pending memory state.

## Configuration
- RV_IF_MISALIGN_CHK_EN defined:
  - A RUN-state `jal` whose target[1] = 1 takes no redirect.
  - It is captured with o_if_id_misalign=1, and the state goes to HALT.
  - HALT exits only on a redirect.
- Undefined:
  - No check; the target is used as computed.
  - o_if_id_misalign is tied 0 and the HALT state is unreachable.

## Structure
- rv_pkg additions: if_state_e (WAIT, RUN, HALT), RV_NOP_INSTR = 32'h0000_0013, OPCODE_JAL = 7'b1101111. XLEN stays in rv_pkg.
- One sub-module, rv_if_jal_dec: combinational. Takes instr and pc, and returns is_jal, target and misalign.

## Test plan
- Reset release with RESET_PC=0, sequential imem image → IF/ID valid at edge 2 with pc 0x0, then 0x4, 0x8 on consecutive cycles.
- `jal x1, +0x100` at 0x8 → next IF/ID pc is 0x108 with no valid=0 gap; the `jal` entry has pc_plus4=0xC.
- i_if_stall high for 3 cycles at pc 0x10 → IF/ID holds pc 0xC and o_if_imem_addr holds 0x10; fetch resumes with 0x10 and no loss or duplicate.
- Redirect to 0x200 together with i_if_stall → next IF/ID valid=0 with instr=NOP; the following IF/ID holds pc 0x200.
- `jal` with offset +0x102 and RV_IF_MISALIGN_CHK_EN set → IF/ID misalign=1 and no further valid instructions; after redirect to 0x40, fetch resumes at 0x40. With the macro unset → fetch continues at pc+0x102.
- PC 0xFFFF_FFFC sequential fetch → next address is 0x0000_0000 (wrap).

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - rv32i shared types and constants for the fetch stage
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } if_state_e;
endpackage

// File: rtl/rv_if_jal_dec.sv
// rtl/rv_if_jal_dec.sv - combinational jal detect and target compute
// misalign is only reported when RV_IF_MISALIGN_CHK_EN is defined
module rv_if_jal_dec
  import rv_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            is_jal,
  output logic [XLEN-1:0] target,
  output logic            misalign
);
  logic [XLEN-1:0] j_imm;
  logic            unused_rd;

  // rd is irrelevant here; the link write is handled by WB from pc_plus4
  assign unused_rd = ^instr[11:7];

  assign j_imm  = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};
  assign is_jal = (instr[6:0] == OPCODE_JAL);
  assign target = pc + j_imm;

`ifdef RV_IF_MISALIGN_CHK_EN
  assign misalign = is_jal & target[1];
`else
  assign misalign = 1'b0;
`endif
endmodule

// File: rtl/rv_if_stage.sv
// rtl/rv_if_stage.sv - rv32i fetch stage: PC, local jal resolve, IF/ID register
// Optional misaligned-jal halt enabled by RV_IF_MISALIGN_CHK_EN
module rv_if_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [XLEN-1:0] o_if_imem_addr,
  input  logic [31:0]     i_if_imem_rdata,
  input  logic            i_if_stall,
  input  logic            i_if_redirect_valid,
  input  logic [XLEN-1:0] i_if_redirect_pc,
  output logic            o_if_id_valid,
  output logic [XLEN-1:0] o_if_id_pc,
  output logic [XLEN-1:0] o_if_id_pc_plus4,
  output logic [31:0]     o_if_id_instr,
  output logic            o_if_id_misalign
);
  if_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_addr;
  logic [XLEN-1:0] jal_target;
  logic            is_jal;
  logic            jal_misalign;
  logic            run;
  logic            jal_bad;

  rv_if_jal_dec u_jal_dec (
    .instr    (i_if_imem_rdata),
    .pc       (pc_q),
    .is_jal   (is_jal),
    .target   (jal_target),
    .misalign (jal_misalign)
  );

  assign run      = (state_q == RUN);
  assign pc_plus4 = pc_q + XLEN'(4);
  assign jal_bad  = run & is_jal & jal_misalign;

  // Any case that holds pc_q re-reads the same word so rdata stays matched to pc_q
  always_comb begin
    next_addr = pc_plus4;
    if (i_if_redirect_valid)
      next_addr = i_if_redirect_pc;
    else if (i_if_stall || !run || jal_bad)
      next_addr = pc_q;
    else if (is_jal)
      next_addr = jal_target;
  end

  assign o_if_imem_addr = next_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= WAIT;
      pc_q             <= RESET_PC;
      o_if_id_valid    <= 1'b0;
      o_if_id_pc       <= '0;
      o_if_id_pc_plus4 <= '0;
      o_if_id_instr    <= RV_NOP_INSTR;
      o_if_id_misalign <= 1'b0;
    end else begin
      pc_q <= next_addr;

      if (i_if_redirect_valid) begin
        state_q <= RUN;
      end else begin
        case (state_q)
          WAIT:    state_q <= RUN;
          RUN:     if (!i_if_stall && jal_bad) state_q <= HALT;
          HALT:    state_q <= HALT;
          default: state_q <= WAIT;
        endcase
      end

      if (i_if_redirect_valid) begin
        o_if_id_valid    <= 1'b0;
        o_if_id_instr    <= RV_NOP_INSTR;
        o_if_id_misalign <= 1'b0;
      end else if (!i_if_stall) begin
        o_if_id_valid    <= run;
        o_if_id_pc       <= pc_q;
        o_if_id_pc_plus4 <= pc_plus4;
        o_if_id_instr    <= i_if_imem_rdata;
        o_if_id_misalign <= jal_bad;
      end
    end
  end
endmodule

// File: tb/tb_rv_if_stage.sv
// tb/tb_rv_if_stage.sv - self-checking bench for rv_if_stage
// Honours RV_IF_MISALIGN_CHK_EN to select the expected misaligned-jal behaviour
module tb_rv_if_stage;
`ifdef RV_IF_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic        id_mis;

  int total = 0;
  int bad   = 0;

  logic [31:0] img [logic [31:0]];

  rv_if_stage #(.RESET_PC(32'h0)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .o_if_imem_addr      (imem_addr),
    .i_if_imem_rdata     (imem_rdata),
    .i_if_stall          (stall),
    .i_if_redirect_valid (rv),
    .i_if_redirect_pc    (rpc),
    .o_if_id_valid       (id_valid),
    .o_if_id_pc          (id_pc),
    .o_if_id_pc_plus4    (id_pc4),
    .o_if_id_instr       (id_instr),
    .o_if_id_misalign    (id_mis)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (img.exists(a)) return img[a];
    return {a[11:0], 20'h00013};
  endfunction

  function automatic logic [31:0] jimm(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  always @(posedge clk) imem_rdata <= mem_read(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks the fetch PC and what IF/ID must hold
  logic [31:0] m_pc;
  bit          primed, halted;
  bit          e_valid, e_nop, e_mis;
  logic [31:0] e_pc, e_pc4, e_instr;

  always @(negedge clk) begin : compare
    logic [31:0] ins, tgt, nxt;
    bit running, jal, badj;
    if (!rst_n) begin
      m_pc = 32'h0; primed = 0; halted = 0;
      e_valid = 0; e_nop = 1; e_mis = 0; e_pc = 0; e_pc4 = 0; e_instr = NOP;
      check("rst_valid", {31'b0, id_valid}, 32'h0);
      check("rst_instr", id_instr, NOP);
      check("rst_pc", id_pc, 32'h0);
      check("rst_pc4", id_pc4, 32'h0);
      check("rst_mis", {31'b0, id_mis}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
    end else begin
      check("m_valid", {31'b0, id_valid}, {31'b0, e_valid});
      if (e_valid || e_nop) check("m_instr", id_instr, e_instr);
      if (e_valid) begin
        check("m_pc", id_pc, e_pc);
        check("m_pc4", id_pc4, e_pc4);
        check("m_mis", {31'b0, id_mis}, {31'b0, e_mis});
      end
      ins     = mem_read(m_pc);
      running = primed && !halted;
      jal     = running && (ins[6:0] == 7'h6F);
      tgt     = m_pc + jimm(ins);
      badj    = CHK && jal && tgt[1];
      if (rv) nxt = rpc;
      else if (stall || !running || badj) nxt = m_pc;
      else if (jal) nxt = tgt;
      else nxt = m_pc + 32'd4;
      check("m_addr", imem_addr, nxt);
      if (rv) begin
        e_valid = 0; e_nop = 1; e_mis = 0; e_instr = NOP;
      end else if (!stall) begin
        e_valid = running; e_nop = 0; e_pc = m_pc; e_pc4 = m_pc + 32'd4;
        e_instr = ins; e_mis = badj;
      end
      if (rv) halted = 0;
      else if (badj && !stall) halted = 1;
      primed = 1;
      m_pc = nxt;
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; rv = 1'b0; rpc = 32'h0;
    img[32'h8]   = 32'h1000_00EF;   // jal x1, +0x100
    img[32'h108] = 32'hEF9F_F06F;   // jal x0, -0x108
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("e1_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("e2_valid", {31'b0, id_valid}, 32'h1);
    check("e2_pc", id_pc, 32'h0);
    tick();
    check("e3_pc", id_pc, 32'h4);
    tick();
    check("jal_pc", id_pc, 32'h8);
    check("jal_pc4", id_pc4, 32'hC);
    check("jal_instr", id_instr, 32'h1000_00EF);
    tick();
    check("jal_tgt_valid", {31'b0, id_valid}, 32'h1);
    check("jal_tgt_pc", id_pc, 32'h108);
    tick();
    check("bjal_tgt_pc", id_pc, 32'h0);

    // stall scenario
    rst_n = 1'b0;
    img.delete();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("pre_stall_pc", id_pc, 32'hC);
    stall = 1'b1;
    #1;
    check("stall_addr", imem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc", id_pc, 32'hC);
      check("stall_hold_addr", imem_addr, 32'h10);
    end
    stall = 1'b0;
    tick();
    check("resume_pc", id_pc, 32'h10);
    tick();
    check("resume_pc2", id_pc, 32'h14);

    // redirect together with stall
    stall = 1'b1; rv = 1'b1; rpc = 32'h200;
    tick();
    stall = 1'b0; rv = 1'b0;
    check("redir_bubble_valid", {31'b0, id_valid}, 32'h0);
    check("redir_bubble_instr", id_instr, NOP);
    tick();
    check("redir_pc", id_pc, 32'h200);
    check("redir_instr", id_instr, 32'h2000_0013);

    // wrap
    rv = 1'b1; rpc = 32'hFFFF_FFFC;
    tick();
    rv = 1'b0;
    #1;
    check("wrap_addr", imem_addr, 32'h0);
    tick();
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);
    tick();
    check("wrap_next_pc", id_pc, 32'h0);

    // misaligned jal, with asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, id_valid}, 32'h0);
    check("async_rst_addr", imem_addr, 32'h0);
    img.delete();
    img[32'h8] = 32'h1020_00EF;     // jal x1, +0x102
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("mjal_pc", id_pc, 32'h8);
    check("mjal_valid", {31'b0, id_valid}, 32'h1);
    check("mjal_mis", {31'b0, id_mis}, {31'b0, CHK});
    tick();
    if (CHK) begin
      for (int i = 0; i < 3; i++) begin
        check("halt_valid", {31'b0, id_valid}, 32'h0);
        check("halt_addr", imem_addr, 32'h8);
        tick();
      end
      rv = 1'b1; rpc = 32'h40;
      tick();
      rv = 1'b0;
      tick();
      check("halt_exit_pc", id_pc, 32'h40);
      check("halt_exit_valid", {31'b0, id_valid}, 32'h1);
      check("halt_exit_mis", {31'b0, id_mis}, 32'h0);
    end else begin
      check("nochk_pc", id_pc, 32'h10A);
      check("nochk_valid", {31'b0, id_valid}, 32'h1);
    end
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
